// File: rtl/mic_capture_sequencer_pkg.sv
// Shared types and defaults for the mic-array ping/record sequencer.
// State encodings, default geometry and counter widths.
package mic_capture_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        BURST,
        DELAY,
        CAPTURE,
        DRAIN,
        DONE
    } state_t;

    localparam int NUM_CH_DEF      = 16;
    localparam int SAMPLE_W_DEF    = 16;
    localparam int BURST_TICKS_DEF = 8;
    localparam int CH_IDX_W        = 4;
    localparam int CNT_W           = 16;

endpackage

// File: rtl/mic_capture_sequencer_if.sv
// Sample stream bundle: one channel word per valid/ready transfer.
interface mic_capture_sequencer_if
    import mic_capture_sequencer_pkg::*;
#(
    parameter int SAMPLE_W = SAMPLE_W_DEF
);
    logic                out_valid;
    logic                out_ready;
    logic [SAMPLE_W-1:0] out_data;
    logic [CH_IDX_W-1:0] out_ch;
    logic                out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_ch,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_ch,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/mic_frame_serializer.sv
// Snapshots one frame of all channels and streams it out channel 0 first.
module mic_frame_serializer
    import mic_capture_sequencer_pkg::*;
#(
    parameter int NUM_CH   = NUM_CH_DEF,
    parameter int SAMPLE_W = SAMPLE_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       load,
    input  logic [NUM_CH*SAMPLE_W-1:0] ch_data,
    output logic                       busy,
    mic_capture_sequencer_if.master    strm
);
    localparam logic [CH_IDX_W-1:0] LAST_CH = CH_IDX_W'(NUM_CH - 1);

    logic [NUM_CH*SAMPLE_W-1:0] snap;
    logic                       xfer;

    assign xfer          = strm.out_valid && strm.out_ready;
    // Free in the cycle the final word is taken, so a back-to-back frame fits.
    assign busy          = strm.out_valid && !(strm.out_last && strm.out_ready);
    assign strm.out_data = snap[SAMPLE_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap           <= '0;
            strm.out_valid <= 1'b0;
            strm.out_ch    <= '0;
            strm.out_last  <= 1'b0;
        end else if (flush) begin
            snap           <= '0;
            strm.out_valid <= 1'b0;
            strm.out_ch    <= '0;
            strm.out_last  <= 1'b0;
        end else if (load) begin
            snap           <= ch_data;
            strm.out_valid <= 1'b1;
            strm.out_ch    <= '0;
            strm.out_last  <= (NUM_CH == 1);
        end else if (xfer && strm.out_last) begin
            strm.out_valid <= 1'b0;
            strm.out_ch    <= '0;
            strm.out_last  <= 1'b0;
        end else if (xfer) begin
            snap           <= snap >> SAMPLE_W;
            strm.out_ch    <= strm.out_ch + 4'd1;
            strm.out_last  <= (strm.out_ch + 4'd1) == LAST_CH;
        end
    end
endmodule

// File: rtl/mic_capture_sequencer.sv
// Ping-and-record sequencer: TX burst, delay, CIC capture, frame streaming.
module mic_capture_sequencer
    import mic_capture_sequencer_pkg::*;
#(
    parameter int NUM_CH      = NUM_CH_DEF,
    parameter int SAMPLE_W    = SAMPLE_W_DEF,
    parameter int BURST_TICKS = BURST_TICKS_DEF
) (
    input  logic                       CLOCK_50,
    input  logic                       rst_n,
    input  logic                       tick_40k,
    input  logic                       start,
    input  logic                       abort,
    input  logic [CNT_W-1:0]           rec_delay_ticks,
    input  logic [CNT_W-1:0]           rec_len,
    input  logic                       sample_valid,
    input  logic [NUM_CH*SAMPLE_W-1:0] ch_data,
    output logic                       tx_en,
    output logic                       mic_on,
    output logic                       busy,
    output logic                       done,
    output logic                       overrun,
    mic_capture_sequencer_if.master    strm
);
    localparam logic [CNT_W-1:0] BT = CNT_W'(BURST_TICKS);

    state_t           state, state_n;
    logic [CNT_W-1:0] tick_cnt, frame_cnt;
    logic [CNT_W-1:0] tick_inc, frame_inc;
    logic [CNT_W-1:0] delay_q, len_q;
    logic             ser_busy, take, load, cap_end, go;
    logic             tx_en_d, mic_on_d, busy_d, done_d;

    assign tick_inc  = tick_cnt + 16'd1;
    assign frame_inc = frame_cnt + 16'd1;
    assign go        = (state == IDLE) && start && !abort;
    assign take      = (state == CAPTURE) && sample_valid
                       && (frame_cnt != len_q) && !abort;
    assign load      = take && !ser_busy;
    // len_q == 0 ends capture on entry without taking a frame.
    assign cap_end   = (frame_cnt == len_q)
                       || (sample_valid && frame_inc == len_q);

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (start) state_n = BURST;
            BURST:   if (tick_40k && tick_inc == BT)
                         state_n = (delay_q == '0) ? CAPTURE : DELAY;
            DELAY:   if (tick_40k && tick_inc == delay_q) state_n = CAPTURE;
            CAPTURE: if (cap_end) state_n = DRAIN;
            DRAIN:   if (!ser_busy) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (abort) state_n = IDLE;
    end

    always_comb begin
        tx_en_d  = (state_n == BURST);
        mic_on_d = (state_n == CAPTURE);
        busy_d   = (state_n != IDLE);
        done_d   = (state_n == DONE);
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            tx_en  <= 1'b0;
            mic_on <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            tx_en  <= tx_en_d;
            mic_on <= mic_on_d;
            busy   <= busy_d;
            done   <= done_d;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt  <= '0;
            frame_cnt <= '0;
            delay_q   <= '0;
            len_q     <= '0;
            overrun   <= 1'b0;
        end else begin
            if (state_n != state)
                tick_cnt <= '0;
            else if (tick_40k && (state == BURST || state == DELAY))
                tick_cnt <= tick_inc;

            if (state == IDLE)
                frame_cnt <= '0;
            else if (take)
                frame_cnt <= frame_inc;

            if (go) begin
                delay_q <= rec_delay_ticks;
                len_q   <= rec_len;
                overrun <= 1'b0;
            end else if (take && ser_busy) begin
                overrun <= 1'b1;
            end
        end
    end

    mic_frame_serializer #(
        .NUM_CH   (NUM_CH),
        .SAMPLE_W (SAMPLE_W)
    ) u_ser (
        .clk     (CLOCK_50),
        .rst_n   (rst_n),
        .flush   (abort),
        .load    (load),
        .ch_data (ch_data),
        .busy    (ser_busy),
        .strm    (strm)
    );
endmodule

// File: tb/tb_mic_capture_sequencer.sv
// Randomised scoreboard bench for mic_capture_sequencer.
module tb_mic_capture_sequencer;
    import mic_capture_sequencer_pkg::*;

    localparam int NCH = 16;
    localparam int SW  = 16;
    localparam int BT  = 8;

    typedef struct packed {
        logic [SW-1:0] data;
        logic [3:0]    ch;
        logic          last;
    } word_t;

    logic              CLOCK_50 = 1'b0;
    logic              rst_n = 1'b0;
    logic              tick_40k = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [15:0]       rec_delay_ticks = '0;
    logic [15:0]       rec_len = '0;
    logic              sample_valid = 1'b0;
    logic [NCH*SW-1:0] ch_data = '0;
    logic              tx_en, mic_on, busy, done, overrun;

    mic_capture_sequencer_if #(.SAMPLE_W(SW)) strm ();

    mic_capture_sequencer #(
        .NUM_CH(NCH), .SAMPLE_W(SW), .BURST_TICKS(BT)
    ) dut (
        .CLOCK_50        (CLOCK_50),
        .rst_n           (rst_n),
        .tick_40k        (tick_40k),
        .start           (start),
        .abort           (abort),
        .rec_delay_ticks (rec_delay_ticks),
        .rec_len         (rec_len),
        .sample_valid    (sample_valid),
        .ch_data         (ch_data),
        .tx_en           (tx_en),
        .mic_on          (mic_on),
        .busy            (busy),
        .done            (done),
        .overrun         (overrun),
        .strm            (strm)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int    total = 0;
    int    bad = 0;
    word_t exp_q[$];

    // reference model state
    bit running;
    int pend, ticks_seen, frames_seen, cfg_delay, cfg_len;
    bit ovr_exp;

    // stimulus configuration and per-run observations
    int cyc, rdy_pct, sv_pct, stall_left;
    bit mode_last, mode_stall, sv_first;
    int tx_ticks, dly_ticks, mic_cycles, done_cnt;
    bit seen_mic, prev_done, prev_abort;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    initial strm.out_ready = 1'b0;

    // Monitor: every presented word is compared to the head of the queue.
    initial begin
        word_t w;
        forever begin
            @(negedge CLOCK_50);
            #1;
            if (rst_n && strm.out_valid && !abort) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 1, 0);
                end else begin
                    w = exp_q[0];
                    check("word", {strm.out_data, strm.out_ch, strm.out_last},
                          {w.data, w.ch, w.last});
                    if (strm.out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic model_step();
        bit acc, free;
        acc = (pend > 0) && strm.out_ready;
        if (abort) begin
            running = 0;
            pend = 0;
            exp_q.delete();
            return;
        end
        if (start && !running) begin
            running = 1;
            ovr_exp = 0;
            ticks_seen = 0;
            frames_seen = 0;
            cfg_delay = int'(rec_delay_ticks);
            cfg_len = int'(rec_len);
            return;
        end
        if (running && ticks_seen >= BT + cfg_delay
            && frames_seen < cfg_len && sample_valid) begin
            frames_seen++;
            free = (pend == 0) || (pend == 1 && acc);
            if (free) begin
                for (int c = 0; c < NCH; c++)
                    exp_q.push_back('{data: ch_data[c*SW +: SW],
                                      ch: 4'(c), last: (c == NCH - 1)});
                pend = NCH;
            end else begin
                ovr_exp = 1;
                if (acc) pend--;
            end
        end else if (acc) begin
            pend--;
        end
        if (running && tick_40k && ticks_seen < BT + cfg_delay)
            ticks_seen++;
    endtask

    task automatic step_cycle(input bit do_start, input int abort_mode,
                              output bit aborted);
        bit ab;
        @(negedge CLOCK_50);
        aborted = 0;
        if (prev_abort) begin
            check("after_abort", {tx_en, mic_on, strm.out_valid, busy, done},
                  5'b0);
            check("overrun_kept", overrun, ovr_exp);
            prev_abort = 0;
        end
        if (prev_done) check("busy_after_done", busy, 0);
        prev_done = done;
        if (done) done_cnt++;
        if (mic_on) begin
            seen_mic = 1;
            mic_cycles++;
        end
        ab = (abort_mode == 1 && busy && !tx_en && !seen_mic && dly_ticks >= 2)
          || (abort_mode == 2 && strm.out_valid && strm.out_ch == 4'd7);

        cyc++;
        tick_40k = (cyc % 4 == 0);
        for (int i = 0; i < NCH * SW / 32; i++)
            ch_data[i*32 +: 32] = $urandom();
        if (!do_start) begin
            rec_delay_ticks = 16'($urandom());
            rec_len = 16'($urandom());
        end
        if (mode_stall && stall_left > 0) begin
            strm.out_ready = 1'b0;
            if (strm.out_valid) stall_left--;
        end else begin
            strm.out_ready = ($urandom_range(99) < rdy_pct);
        end
        if (mode_last) begin
            sample_valid = mic_on && (!sv_first
                           || (strm.out_valid && strm.out_ch == 4'd15));
            if (sample_valid) sv_first = 1;
        end else begin
            sample_valid = ($urandom_range(99) < sv_pct)
                        || (mode_stall && stall_left == 20 && mic_on);
        end
        start = do_start || (busy && $urandom_range(99) < 3);
        abort = ab;
        if (ab) strm.out_ready = 1'b0;
        if (tx_en && tick_40k) tx_ticks++;
        if (busy && !tx_en && !seen_mic && tick_40k) dly_ticks++;
        model_step();
        if (ab) begin
            prev_abort = 1;
            aborted = 1;
        end
    endtask

    task automatic run(input int dly, input int len, input int rdy,
                       input int svp, input bit mlast, input bit mstall,
                       input int abort_mode);
        bit ab, finished, was_aborted;
        rdy_pct = rdy; sv_pct = svp; mode_last = mlast; mode_stall = mstall;
        stall_left = 40; sv_first = 0;
        tx_ticks = 0; dly_ticks = 0; mic_cycles = 0; done_cnt = 0;
        seen_mic = 0; prev_done = 0; prev_abort = 0;
        finished = 0; was_aborted = 0;
        rec_delay_ticks = 16'(dly);
        rec_len = 16'(len);
        step_cycle(1, 0, ab);
        for (int n = 0; n < 20000; n++) begin
            step_cycle(0, abort_mode, ab);
            if (ab) begin
                was_aborted = 1;
                step_cycle(0, 0, ab);
                finished = 1;
                break;
            end
            if (done_cnt > 0 && !busy) begin
                finished = 1;
                break;
            end
        end
        running = 0;
        if (!finished) check("run_timeout", 1, 0);
        check("done_count", done_cnt, was_aborted ? 0 : 1);
        check("queue_empty", exp_q.size(), 0);
        if (!was_aborted) begin
            check("burst_ticks", tx_ticks, BT);
            check("delay_ticks", dly_ticks, dly);
            check("overrun", overrun, ovr_exp);
            if (len == 0) check("mic_on_short", mic_cycles <= 1, 1);
        end
        exp_q.delete();
        pend = 0;
    endtask

    initial begin
        bit ab;
        running = 0; pend = 0; ovr_exp = 0; cyc = 0;
        repeat (3) @(negedge CLOCK_50);
        check("reset_outs", {tx_en, mic_on, busy, done, overrun,
              strm.out_valid, strm.out_last, strm.out_ch, strm.out_data}, '0);
        rst_n = 1'b1;

        run(4, 2, 100, 3, 0, 0, 0);
        run(0, 0, 100, 50, 0, 0, 0);
        run(2, 3, 100, 5, 0, 1, 0);
        check("stall_overrun", overrun, 1);
        run(1, 4, 100, 0, 1, 0, 0);
        check("back_to_back_no_overrun", overrun, 0);
        run(10, 2, 100, 5, 0, 0, 1);
        run(1, 3, 100, 20, 0, 0, 2);
        for (int r = 0; r < 8; r++)
            run($urandom_range(5), $urandom_range(4), $urandom_range(100, 30),
                $urandom_range(20, 2), 0, 0, 0);

        mode_last = 0; mode_stall = 0; rdy_pct = 100; sv_pct = 0;
        rec_delay_ticks = 16'd2;
        rec_len = 16'd1;
        step_cycle(1, 0, ab);
        repeat (5) step_cycle(0, 0, ab);
        check("tx_en_in_burst", tx_en, 1);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset", {tx_en, mic_on, busy, done, overrun,
              strm.out_valid}, '0);
        start = 0; abort = 0; sample_valid = 0;
        running = 0; pend = 0; exp_q.delete();
        @(negedge CLOCK_50);
        rst_n = 1'b1;
        @(negedge CLOCK_50);
        check("idle_after_reset", {tx_en, busy}, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
